// File: rtl/fsk_tone_detect.sv
// FSK receive tone detector: measures input periods in mainclk cycles, classifies mark/space, declares lock.
// Optional saturating err_cnt register is built only when `FSK_TONE_ERR_COUNT_EN is defined.
module fsk_tone_detect #(
    parameter int T1_PERIOD = 34,
    parameter int T0_PERIOD = 68,
    parameter int TOL       = 4,
    parameter int LOCK_N    = 4,
    parameter int CNT_W     = 9
) (
    input  logic       mainclk,
    input  logic       reset,
    input  logic       fsk_in,
    output logic       tone_bit,
    output logic       locked,
    output logic       sym_stb,
    output logic [7:0] err_cnt
);
    localparam int RUN_W = $clog2(LOCK_N + 1);
    localparam int CW1   = CNT_W + 1;

    localparam logic [0:0] SEEK  = 1'b0;
    localparam logic [0:0] TRACK = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(T0_PERIOD + TOL);
    localparam logic [CNT_W:0]   T1_LO   = CW1'(T1_PERIOD - TOL);
    localparam logic [CNT_W:0]   T1_HI   = CW1'(T1_PERIOD + TOL);
    localparam logic [CNT_W:0]   T0_LO   = CW1'(T0_PERIOD - TOL);
    localparam logic [CNT_W:0]   T0_HI   = CW1'(T0_PERIOD + TOL);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_N);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    logic             s1, s2, s3;
    logic             rise;
    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   period;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_next;
    logic             prev_cls;
    logic             is_one, is_zero, cls_valid, cls;
    logic             timeout;
    logic             lock_evt;

    always_ff @(posedge mainclk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= fsk_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise      = s2 & ~s3;
    assign period    = {1'b0, cnt} + CW1'(1);
    assign is_one    = (period >= T1_LO) && (period <= T1_HI);
    assign is_zero   = (period >= T0_LO) && (period <= T0_HI);
    assign cls_valid = is_one | is_zero;
    assign cls       = is_one;
    // A rise in the same cycle as the limit wins; that over-long period is simply invalid.
    assign timeout   = (state == TRACK) && !rise && (cnt == CNT_MAX);

    always_comb begin
        run_next = run_cnt;
        if (cls == prev_cls) begin
            if (run_cnt != RUN_MAX) begin
                run_next = run_cnt + RUN_ONE;
            end
        end else begin
            run_next = RUN_ONE;
        end
    end

    assign lock_evt = (state == TRACK) && rise && cls_valid && (run_next == RUN_MAX) &&
                      ((run_cnt != RUN_MAX) || (cls != prev_cls));

    always_ff @(posedge mainclk or posedge reset) begin
        if (reset) begin
            state    <= SEEK;
            cnt      <= '0;
            run_cnt  <= '0;
            prev_cls <= 1'b0;
            locked   <= 1'b0;
            tone_bit <= 1'b0;
            sym_stb  <= 1'b0;
        end else begin
            sym_stb <= 1'b0;
            case (state)
                SEEK: begin
                    cnt <= '0;
                    if (rise) begin
                        state <= TRACK;
                    end
                end
                TRACK: begin
                    if (rise) begin
                        cnt <= '0;
                        if (cls_valid) begin
                            run_cnt  <= run_next;
                            prev_cls <= cls;
                            if (cls != prev_cls) begin
                                locked <= 1'b0;
                            end
                            if (lock_evt) begin
                                locked   <= 1'b1;
                                tone_bit <= cls;
                                sym_stb  <= 1'b1;
                            end
                        end else begin
                            run_cnt <= '0;
                            locked  <= 1'b0;
                        end
                    end else if (timeout) begin
                        state   <= SEEK;
                        cnt     <= '0;
                        run_cnt <= '0;
                        locked  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= SEEK;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef FSK_TONE_ERR_COUNT_EN
    logic       err_inc;
    logic [7:0] err_q;

    assign err_inc = ((state == TRACK) && rise && !cls_valid) || timeout;

    always_ff @(posedge mainclk or posedge reset) begin
        if (reset) begin
            err_q <= 8'd0;
        end else if (err_inc && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_fsk_tone_detect.sv
// Testbench for fsk_tone_detect: period-level stimulus checked every cycle against an edge-timing model.
module tb_fsk_tone_detect;
    localparam int T1   = 34;
    localparam int T0   = 68;
    localparam int TOL  = 4;
    localparam int LOCK = 4;
`ifdef FSK_TONE_ERR_COUNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       mainclk = 1'b0;
    logic       reset   = 1'b0;
    logic       fsk_in  = 1'b0;
    logic       tone_bit;
    logic       locked;
    logic       sym_stb;
    logic [7:0] err_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int stb_seen = 0;

    // Model state: time-based view of the spec (edges between rises, not a counter).
    bit smp_q[$];
    int n_edge;
    bit m_armed;
    int m_last;
    int m_prev;
    int m_run;
    bit m_locked;
    bit m_tone;
    bit m_stb;
    int m_err;

    fsk_tone_detect #(
        .T1_PERIOD(T1), .T0_PERIOD(T0), .TOL(TOL), .LOCK_N(LOCK), .CNT_W(9)
    ) dut (
        .mainclk (mainclk),
        .reset   (reset),
        .fsk_in  (fsk_in),
        .tone_bit(tone_bit),
        .locked  (locked),
        .sym_stb (sym_stb),
        .err_cnt (err_cnt)
    );

    always #5 mainclk = ~mainclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, n_edge);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic err_bump();
        if (ERR_EN && m_err < 255) m_err++;
    endtask

    task automatic model_reset();
        smp_q    = '{0, 0, 0, 0};
        m_armed  = 0;
        m_last   = 0;
        m_prev   = 0;
        m_run    = 0;
        m_locked = 0;
        m_tone   = 0;
        m_stb    = 0;
        m_err    = 0;
    endtask

    // Input sampled at edge k shows up as a registered rise at edge k+2.
    task automatic model_step(input bit v);
        bit r;
        int p;
        int c;
        int nrun;
        n_edge++;
        smp_q.push_front(v);
        void'(smp_q.pop_back());
        r = smp_q[2] && !smp_q[3];
        m_stb = 0;
        if (r) begin
            if (!m_armed) begin
                m_armed = 1;
                m_last  = n_edge;
            end else begin
                p = n_edge - m_last;
                m_last = n_edge;
                if (iabs(p - T1) <= TOL) c = 1;
                else if (iabs(p - T0) <= TOL) c = 0;
                else c = -1;
                if (c < 0) begin
                    m_run    = 0;
                    m_locked = 0;
                    err_bump();
                end else begin
                    nrun = (c == m_prev) ? ((m_run < LOCK) ? m_run + 1 : LOCK) : 1;
                    if (c != m_prev) m_locked = 0;
                    if (nrun == LOCK && (m_run != LOCK || c != m_prev)) begin
                        m_locked = 1;
                        m_tone   = (c == 1);
                        m_stb    = 1;
                    end
                    m_run  = nrun;
                    m_prev = c;
                end
            end
        end else if (m_armed && (n_edge - m_last) == T0 + TOL + 1) begin
            m_armed  = 0;
            m_locked = 0;
            m_run    = 0;
            err_bump();
        end
    endtask

    task automatic drive_cycle(input bit v);
        @(negedge mainclk);
        fsk_in = v;
        @(posedge mainclk);
        #1;
        model_step(v);
        check("locked", 32'(locked), 32'(m_locked));
        check("tone_bit", 32'(tone_bit), 32'(m_tone));
        check("sym_stb", 32'(sym_stb), 32'(m_stb));
        check("err_cnt", 32'(err_cnt), 32'(m_err));
        if (sym_stb === 1'b1) stb_seen++;
    endtask

    task automatic send_period(input int p);
        for (int i = 0; i < p; i++) begin
            drive_cycle(i < p / 2);
        end
    endtask

    task automatic hold_low(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0);
    endtask

    // Reset asserted between edges must clear outputs without any clock.
    task automatic async_reset(input string tag);
        @(negedge mainclk);
        #2;
        reset  = 1'b1;
        fsk_in = 1'b0;
        #1;
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_tone_bit"}, 32'(tone_bit), 32'd0);
        check({tag, "_sym_stb"}, 32'(sym_stb), 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        repeat (2) @(posedge mainclk);
        @(negedge mainclk);
        reset = 1'b0;
        model_reset();
    endtask

    int err_before;
    int sel;
    int p;

    initial begin
        n_edge = 0;
        model_reset();
        #1;
        async_reset("reset");

        // Mark lock: 6 periods of 34, one strobe.
        stb_seen = 0;
        for (int i = 0; i < 6; i++) send_period(T1);
        check("mark_stb_count", 32'(stb_seen), 32'd1);
        check("mark_locked", 32'(locked), 32'd1);
        check("mark_tone", 32'(tone_bit), 32'd1);

        // Tone switch to space.
        stb_seen = 0;
        for (int i = 0; i < 5; i++) send_period(T0);
        check("space_stb_count", 32'(stb_seen), 32'd1);
        check("space_locked", 32'(locked), 32'd1);
        check("space_tone", 32'(tone_bit), 32'd0);

        // Tolerance edges.
        send_period(30); send_period(38); send_period(30); send_period(38); send_period(30);
        check("tol1_locked", 32'(locked), 32'd1);
        check("tol1_tone", 32'(tone_bit), 32'd1);
        send_period(64); send_period(72); send_period(64); send_period(72); send_period(64);
        check("tol0_locked", 32'(locked), 32'd1);
        check("tol0_tone", 32'(tone_bit), 32'd0);
        err_before = int'(err_cnt);
        send_period(29); send_period(39); send_period(63); send_period(T1);
        check("invalid_err", 32'(err_cnt), ERR_EN ? 32'(err_before + 3) : 32'd0);
        check("invalid_locked", 32'(locked), 32'd0);
        // Rise on the timeout cycle (73) and just after it (74).
        send_period(T1); send_period(73); send_period(74); send_period(T1); send_period(T1);

        // Stall after lock.
        for (int i = 0; i < 6; i++) send_period(T1);
        check("stall_pre_locked", 32'(locked), 32'd1);
        err_before = int'(err_cnt);
        hold_low(80);
        check("stall_locked", 32'(locked), 32'd0);
        check("stall_err", 32'(err_cnt), ERR_EN ? 32'(err_before + 1) : 32'd0);
        for (int i = 0; i < 4; i++) send_period(T1);
        check("stall_arm_only", 32'(locked), 32'd0);
        send_period(T1);
        check("stall_relock", 32'(locked), 32'd1);

        // Reset mid-lock.
        send_period(T1);
        async_reset("midlock");
        for (int i = 0; i < 4; i++) send_period(T1);
        check("rst_arm_only", 32'(locked), 32'd0);
        send_period(T1);
        check("rst_relock", 32'(locked), 32'd1);
        check("rst_tone", 32'(tone_bit), 32'd1);

        // Saturation of err_cnt.
        for (int i = 0; i < 300; i++) send_period(50);
        check("sat_err", 32'(err_cnt), ERR_EN ? 32'd255 : 32'd0);
        send_period(50);
        check("sat_hold", 32'(err_cnt), ERR_EN ? 32'd255 : 32'd0);

        // Randomized periods around both tones and in between.
        async_reset("rand_rst");
        for (int i = 0; i < 150; i++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0, 3: p = T1 + int'($urandom_range(0, 12)) - 6;
                1:    p = T0 + int'($urandom_range(0, 12)) - 6;
                default: p = int'($urandom_range(25, 80));
            endcase
            send_period(p);
        end
        hold_low(80);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fsk_tone_detect.md
# fsk_tone_detect

Receive-side tone detector for the FSK link. It sees the incoming FSK square wave as a single asynchronous bit. It measures each waveform period in `mainclk` cycles and classifies the period as mark tone (bit 1), space tone (bit 0) or invalid. It declares lock on a tone after a run of agreeing periods. It sits between the line input and the symbol/bit deframer, and is the counterpart of the transmit-side divided-clock tone generation.

## Interface
- `T1_PERIOD`, default 34: mark-tone period in `mainclk` cycles (bit 1).
- `T0_PERIOD`, default 68: space-tone period in `mainclk` cycles (bit 0).
- `TOL`, default 4: accepted ± deviation in cycles. Must satisfy `T1_PERIOD+TOL < T0_PERIOD-TOL`.
- `LOCK_N`, default 4: consecutive agreeing periods required for lock.
- `CNT_W`, default 9: period counter width. Must hold `T0_PERIOD+TOL+1`.
- `mainclk` input 1: the single clock. Registers update on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `fsk_in` input 1: asynchronous FSK square wave.
- `tone_bit` output 1: decided bit. Valid while `locked`=1.
- `locked` output 1: lock indicator.
- `sym_stb` output 1: one-cycle pulse on each lock acquisition.
- `err_cnt` output 8: saturating count of invalid periods.

## Operation
- **Input sync:** `fsk_in` → s1 → s2 → s3 flops. `rise` = s2 & ~s3, combinational.
- **Period counter `cnt`:** loads 0 on a cycle with `rise`, otherwise increments. Held at 0 in SEEK. Measured period P = `cnt`+1 at a rise.
- **State SEEK (reset state):**
  - On `rise` → TRACK, `cnt`←0.
  - No classification is made.
- **State TRACK, on `rise`:** classify P.
  - |P−T1_PERIOD| ≤ TOL → class 1.
  - |P−T0_PERIOD| ≤ TOL → class 0.
  - Otherwise → invalid.
- **Run counter `run_cnt`,** saturating at LOCK_N:
  - Valid class equal to the previous class → `run_cnt`+1.
  - Valid class different from the previous class → `run_cnt`=1, class recorded, `locked`←0.
  - Invalid → `run_cnt`=0, `locked`←0, `err_cnt`+1.
- **Lock:** when `run_cnt` becomes LOCK_N:
  - `locked`←1 and `tone_bit`←class.
  - `sym_stb`=1 for that one cycle only.
  - Further agreeing periods keep `locked`=1 with no new strobe.
- **Timeout:** in TRACK with no `rise` and `cnt` = T0_PERIOD+TOL:
  - → SEEK.
  - `locked`←0, `run_cnt`←0, `err_cnt`+1.
- **Simultaneous events:** `rise` has priority over timeout. That period (P = T0_PERIOD+TOL+1) is classified invalid, and the block stays in TRACK.
- **`err_cnt`:** holds at 255 and never wraps.
- **`tone_bit`:** keeps its last value when `locked` falls.

## Timing
- **Reset values:** `tone_bit`=0, `locked`=0, `sym_stb`=0, `err_cnt`=0. Also s1/s2/s3=0, `cnt`=0, `run_cnt`=0, state SEEK. All take effect immediately on `reset` assertion, with no clock needed.
- **Reset mid-operation:** aborts any measurement. After release, the first rise only arms the block (SEEK→TRACK).
- **Latency:** `fsk_in` rising before `mainclk` edge k → outputs update at edge k+2.
- **Lock time:** from SEEK, `locked` rises at edge k+2 of the (LOCK_N+1)-th rising edge. The first edge only arms the block.
- **Timeout edge:** E = the edge registering the last `rise`. `locked` falls at edge E+T0_PERIOD+TOL+1 if no rise occurs (default: E+73).

## Configuration
- Macro: `FSK_TONE_ERR_COUNT_EN`.
- **Defined:** the 8-bit saturating `err_cnt` is implemented as specified.
- **Undefined:** no counter register; `err_cnt` is tied to 8'd0. All other behaviour is identical.

## Test plan
- **Mark lock:** reset, then 6 periods of 34 cycles → `locked` 0→1 at edge k+2 of the 5th rise; one `sym_stb` pulse; `tone_bit`=1; no further strobe on the 6th period.
- **Tone switch:** after mark lock, periods of 68 → `locked` falls 2 cycles after the first 68-period rise; relocks after the 4th 68-period with `tone_bit`=0 and one `sym_stb`.
- **Tolerance edges:**
  - Periods 30 and 38 → class 1.
  - Periods 64 and 72 → class 0.
  - Period 29, 39 or 63 → invalid: `err_cnt`+1, `locked`=0, `run_cnt`=0.
- **Stall:** lock with defaults, then hold `fsk_in` low → `locked` falls at edge E+73; state SEEK; `err_cnt`+1. The next rise only arms the block.
- **Reset mid-lock:** assert `reset` between clock edges → all outputs 0 immediately. After release, 5 rises of period 34 are needed to relock.
- **Saturation / config:**
  - With the macro defined: 300 invalid periods of 50 cycles → `err_cnt`=255 and holds.
  - With the macro undefined: the same stimulus → `err_cnt`=0 throughout.
